envelope_follower: RTL and testbench

Per-band amplitude envelope extractor for the vocoder datapath. It sits directly upstream of the mixer and drives its `envelope_channels` input. On each sample strobe it captures the N_FILTERS modulator band-pass outputs. It then runs a time-multiplexed rectify-and-smooth pass over the channels, one per cycle, with separate attack and release time constants, and presents all updated envelopes together with a one-cycle `valid_out`.

---
 rtl/envelope_follower.sv | 120 ++++++++++++
 tb/tb_envelope_follower.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/envelope_follower.sv
// Per-band rectify-and-smooth envelope extractor, one channel per cycle.
// Optional ENV_OVERRUN_CNT_EN adds a saturating dropped-strobe counter.
module envelope_follower #(
  parameter int N_FILTERS     = 8,
  parameter int ATTACK_SHIFT  = 4,
  parameter int RELEASE_SHIFT = 10
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               valid_in,
  input  logic signed [31:0] band_channels [N_FILTERS-1:0],
  output logic signed [31:0] envelope_channels [N_FILTERS-1:0],
`ifdef ENV_OVERRUN_CNT_EN
  output logic [15:0]        overrun_count_out,
`endif
  output logic               valid_out,
  output logic               busy_out
);

  localparam int IW = $clog2(N_FILTERS);
  localparam logic [IW-1:0] LAST = IW'(N_FILTERS - 1);
  localparam logic signed [31:0] S_MIN = 32'sh8000_0000;
  localparam logic [31:0] S_MAX = 32'h7fff_ffff;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0]      idx;
  logic signed [31:0] cap [N_FILTERS-1:0];
  logic signed [31:0] env [N_FILTERS-1:0];

  logic signed [31:0] x;
  logic signed [31:0] env_cur;
  logic [31:0]        a;
  logic signed [32:0] diff;
  logic signed [32:0] step;
  logic [31:0]        env_nxt;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state: accept in IDLE, sweep channels in RUN, publish in DONE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (valid_in) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rectify, compare against the current envelope and take one step
  always_comb begin
    x       = cap[idx];
    env_cur = env[idx];
    if (x == S_MIN)  a = S_MAX;
    else if (x[31])  a = 32'(-x);
    else             a = x;
    diff = $signed({1'b0, a}) - $signed({1'b0, env_cur});
    if (!diff[32] && diff != '0)
      step = diff >>> ATTACK_SHIFT;
    else
      step = diff >>> RELEASE_SHIFT;
    // a positive error smaller than the shift would stall short of target
    if (diff != '0 && step == '0)
      step = 33'sd1;
    env_nxt = env_cur + step[31:0];
  end

  // Capture buffer, per-channel state, output registers and strobes
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx       <= '0;
      valid_out <= 1'b0;
      busy_out  <= 1'b0;
      for (int k = 0; k < N_FILTERS; k++) begin
        cap[k]               <= '0;
        env[k]               <= '0;
        envelope_channels[k] <= '0;
      end
    end else begin
      valid_out <= (state == DONE);
      busy_out  <= (state_nxt != IDLE);
      if (state == IDLE && valid_in) begin
        idx <= '0;
        for (int k = 0; k < N_FILTERS; k++)
          cap[k] <= band_channels[k];
      end
      if (state == RUN) begin
        env[idx] <= env_nxt;
        idx      <= idx + 1'b1;
      end
      if (state == DONE) begin
        for (int k = 0; k < N_FILTERS; k++)
          envelope_channels[k] <= env[k];
      end
    end
  end

`ifdef ENV_OVERRUN_CNT_EN
  // Count strobes dropped while a frame is in flight, saturating
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      overrun_count_out <= '0;
    else if (valid_in && state != IDLE && overrun_count_out != 16'hFFFF)
      overrun_count_out <= overrun_count_out + 16'd1;
  end
`endif

endmodule

// File: tb/tb_envelope_follower.sv
// Randomized bench for envelope_follower against an arithmetic model.
// Overrun counter checks are active when ENV_OVERRUN_CNT_EN is defined.
module tb_envelope_follower;

  localparam int N   = 8;
  localparam int ATT = 4;
  localparam int REL = 10;

  logic               clk_in;
  logic               rst_n_in;
  logic               valid_in;
  logic signed [31:0] band [N-1:0];
  logic signed [31:0] env_o [N-1:0];
  logic               valid_out;
  logic               busy_out;
`ifdef ENV_OVERRUN_CNT_EN
  logic [15:0]        ovf;
`endif

  envelope_follower #(
    .N_FILTERS(N),
    .ATTACK_SHIFT(ATT),
    .RELEASE_SHIFT(REL)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .valid_in(valid_in),
    .band_channels(band),
    .envelope_channels(env_o),
`ifdef ENV_OVERRUN_CNT_EN
    .overrun_count_out(ovf),
`endif
    .valid_out(valid_out),
    .busy_out(busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int drops  = 0;
  longint env_m [N];
  logic signed [31:0] stim [N];

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint mstep(input longint e, input longint x);
    longint a, d, s, da, dr;
    da = longint'(1) << ATT;
    dr = longint'(1) << REL;
    a = (x < 0) ? -x : x;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    d = a - e;
    if (d > 0)       s = d / da;
    else if (d == 0) s = 0;
    else             s = -((-d + dr - 1) / dr);
    if (d != 0 && s == 0) s = 1;
    return e + s;
  endfunction

  task automatic drive_band();
    for (int k = 0; k < N; k++) band[k] = stim[k];
  endtask

  task automatic model_frame();
    for (int k = 0; k < N; k++) env_m[k] = mstep(env_m[k], longint'(stim[k]));
  endtask

  task automatic chk_envs(input string tag);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_env%0d", tag, k), longint'(env_o[k]), env_m[k]);
  endtask

  // Starts #1 after a clock edge; ends #1 after the valid_out edge.
  task automatic run_frame(input string tag, input bit junk);
    bit got;
    drive_band();
    valid_in = 1'b1;
    model_frame();
    @(posedge clk_in); #1;
    got = 1'b0;
    for (int c = 1; c <= 14 && !got; c++) begin
      valid_in = junk && (c == 4);
      if (junk && c == 4) begin
        for (int k = 0; k < N; k++) band[k] = $urandom;
        drops++;
      end
      @(posedge clk_in); #1;
      if (c == 1) chk({tag, "_busy_rise"}, busy_out, 1);
      if (valid_out) begin
        got = 1'b1;
        chk({tag, "_latency"}, c, N + 1);
        chk({tag, "_busy_fall"}, busy_out, 0);
        chk_envs(tag);
      end
    end
    valid_in = 1'b0;
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    bit seen;
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    for (int k = 0; k < N; k++) begin
      band[k]  = '0;
      env_m[k] = 0;
    end
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_env0", env_o[0], 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy_out, 0);
`ifdef ENV_OVERRUN_CNT_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    for (int k = 0; k < N; k++) stim[k] = 32'sd1000;
    run_frame("atk1", 1'b0);
    chk("atk1_const", env_o[3], 62);
    run_frame("atk2", 1'b0);
    chk("atk2_const", env_o[5], 120);

    for (int k = 0; k < N; k++) stim[k] = 32'sd0;
    run_frame("rel", 1'b0);
    chk("rel_const", env_o[0], 119);

    for (int k = 0; k < N; k++) stim[k] = 32'sd777;
    drive_band();
    valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #3;
    rst_n_in = 1'b0;
    #1;
    chk("midrst_env0", env_o[0], 0);
    chk("midrst_env7", env_o[N-1], 0);
    chk("midrst_valid", valid_out, 0);
    chk("midrst_busy", busy_out, 0);
    for (int k = 0; k < N; k++) env_m[k] = 0;
    drops = 0;
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk_in); #1;
      if (valid_out) seen = 1'b1;
    end
    chk("midrst_no_valid", seen, 0);

    for (int k = 0; k < N; k++) stim[k] = 32'(1000 * k);
    stim[0] = 32'sd5;
    stim[1] = 32'sh8000_0000;
    run_frame("edge", 1'b0);
    chk("minstep", env_o[0], 1);
    chk("satabs", env_o[1], 134217727);

    for (int cyc = 0; cyc < 22; cyc++) begin
      valid_in = (cyc == 0 || cyc == 3 || cyc == 10);
      if (cyc == 0 || cyc == 10) begin
        for (int k = 0; k < N; k++) stim[k] = $urandom;
        drive_band();
        model_frame();
      end else if (cyc == 3) begin
        for (int k = 0; k < N; k++) band[k] = $urandom;
        drops++;
      end
      @(posedge clk_in); #1;
      chk($sformatf("ovr_valid_c%0d", cyc), valid_out,
          longint'(cyc == 9 || cyc == 19));
      if (cyc == 9 || cyc == 19) chk_envs($sformatf("ovr_c%0d", cyc));
    end
    valid_in = 1'b0;
`ifdef ENV_OVERRUN_CNT_EN
    chk("ovr_count", ovf, 1);
`endif

    for (int f = 0; f < 50; f++) begin
      for (int k = 0; k < N; k++) begin
        case (f % 3)
          0:       stim[k] = 32'(1000 * k * (f % 7 + 1));
          1:       stim[k] = $urandom;
          default: stim[k] = 32'($urandom_range(0, 4000)) - 32'sd2000;
        endcase
        if ($urandom_range(0, 15) == 0) stim[k] = 32'sh8000_0000;
      end
      run_frame($sformatf("rnd%0d", f), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk_in);
      #0;
    end
`ifdef ENV_OVERRUN_CNT_EN
    chk("final_ovf", ovf, drops);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
